// File: rtl/sudoku_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_ctrl
//  Purpose  : Game-control stage in front of the Sudoku datapath. Sequences
//             user button presses into one-hot command flags with a
//             registered operand, latches per-game random seeds from a
//             free-running LFSR and tracks the won condition.
//  Revision : 1.0  initial release
// ============================================================================
module sudoku_ctrl #(
    parameter int          FLAG_CYCLES = 2,        // flag high time, 1..7
    parameter logic [11:0] LFSR_SEED   = 12'hACE   // nonzero reset value
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       btn_new_game,
    input  logic       btn_enter,
    input  logic [1:0] user_data,
    input  logic       solved,
    output logic       new_game,
    output logic       set_board_flag,
    output logic       set_diff_flag,
    output logic       row_flag,
    output logic       col_flag,
    output logic       val_flag,
    output logic       check_flag,
    output logic [1:0] diff_cell_val,
    output logic [3:0] rand_setup,
    output logic [3:0] rand_A,
    output logic [3:0] rand_B,
    output logic       game_won
);

    localparam logic [3:0] c_S_IDLE   = 4'd0;
    localparam logic [3:0] c_S_NEW    = 4'd1;
    localparam logic [3:0] c_S_BOARD  = 4'd2;
    localparam logic [3:0] c_S_DIFF_W = 4'd3;
    localparam logic [3:0] c_S_DIFF_F = 4'd4;
    localparam logic [3:0] c_S_ROW_W  = 4'd5;
    localparam logic [3:0] c_S_ROW_F  = 4'd6;
    localparam logic [3:0] c_S_COL_W  = 4'd7;
    localparam logic [3:0] c_S_COL_F  = 4'd8;
    localparam logic [3:0] c_S_VAL_W  = 4'd9;
    localparam logic [3:0] c_S_VAL_F  = 4'd10;
    localparam logic [3:0] c_S_CHECK  = 4'd11;
    localparam logic [3:0] c_S_WON    = 4'd12;

    // Counter value on the last cycle of a flag window
    localparam logic [2:0] c_CNT_LAST = 3'(FLAG_CYCLES - 1);

    logic [3:0]  r_state;
    logic [3:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_load_op;
    logic        w_in_flag;
    logic        w_flag_done;
    logic [11:0] r_lfsr;

    logic w_new_game;
    logic w_set_board;
    logic w_set_diff;
    logic w_row;
    logic w_col;
    logic w_val;
    logic w_check;
    logic w_won;

    // State and flag-width counter registers
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Free-running seed generator, x^12+x^6+x^4+x+1 (never leaves nonzero set)
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[10:0], r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0]};
        end
    end

    // Next-state, operand-load and counter logic; new game overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_load_op   = 1'b0;
        w_in_flag   = (r_state == c_S_BOARD)  || (r_state == c_S_DIFF_F) ||
                      (r_state == c_S_ROW_F)  || (r_state == c_S_COL_F)  ||
                      (r_state == c_S_VAL_F);
        w_flag_done = (r_cnt == c_CNT_LAST);

        if (btn_new_game) begin
            w_state_nxt = c_S_NEW;
        end else begin
            case (r_state)
                c_S_IDLE:   w_state_nxt = c_S_IDLE;
                c_S_NEW:    w_state_nxt = c_S_BOARD;
                c_S_BOARD:  if (w_flag_done) w_state_nxt = c_S_DIFF_W;
                c_S_DIFF_W: if (btn_enter) begin
                                w_state_nxt = c_S_DIFF_F;
                                w_load_op   = 1'b1;
                            end
                c_S_DIFF_F: if (w_flag_done) w_state_nxt = c_S_ROW_W;
                c_S_ROW_W:  if (btn_enter) begin
                                w_state_nxt = c_S_ROW_F;
                                w_load_op   = 1'b1;
                            end
                c_S_ROW_F:  if (w_flag_done) w_state_nxt = c_S_COL_W;
                c_S_COL_W:  if (btn_enter) begin
                                w_state_nxt = c_S_COL_F;
                                w_load_op   = 1'b1;
                            end
                c_S_COL_F:  if (w_flag_done) w_state_nxt = c_S_VAL_W;
                c_S_VAL_W:  if (btn_enter) begin
                                w_state_nxt = c_S_VAL_F;
                                w_load_op   = 1'b1;
                            end
                c_S_VAL_F:  if (w_flag_done) w_state_nxt = c_S_CHECK;
                // Last check_flag cycle: the datapath verdict is valid here
                c_S_CHECK:  w_state_nxt = solved ? c_S_WON : c_S_ROW_W;
                c_S_WON:    w_state_nxt = c_S_WON;
                default:    w_state_nxt = c_S_IDLE;
            endcase
        end

        // Counter restarts on every state change, counts only inside flag windows
        w_cnt_nxt = '0;
        if ((w_state_nxt == r_state) && w_in_flag) begin
            w_cnt_nxt = r_cnt + 3'd1;
        end
    end

    // Output decode from the upcoming state so registered outputs track the state
    always_comb begin
        w_new_game  = (w_state_nxt == c_S_NEW);
        w_set_board = (w_state_nxt == c_S_BOARD);
        w_set_diff  = (w_state_nxt == c_S_DIFF_F);
        w_row       = (w_state_nxt == c_S_ROW_F);
        w_col       = (w_state_nxt == c_S_COL_F);
        w_val       = (w_state_nxt == c_S_VAL_F);
        w_check     = (w_state_nxt == c_S_VAL_F) || (w_state_nxt == c_S_CHECK);
        w_won       = (w_state_nxt == c_S_WON);
    end

    // Output registers: flags, operand capture and per-game seed latch
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            new_game       <= 1'b0;
            set_board_flag <= 1'b0;
            set_diff_flag  <= 1'b0;
            row_flag       <= 1'b0;
            col_flag       <= 1'b0;
            val_flag       <= 1'b0;
            check_flag     <= 1'b0;
            game_won       <= 1'b0;
            diff_cell_val  <= 2'b00;
            rand_setup     <= 4'h0;
            rand_A         <= 4'h0;
            rand_B         <= 4'h0;
        end else begin
            new_game       <= w_new_game;
            set_board_flag <= w_set_board;
            set_diff_flag  <= w_set_diff;
            row_flag       <= w_row;
            col_flag       <= w_col;
            val_flag       <= w_val;
            check_flag     <= w_check;
            game_won       <= w_won;
            if (w_load_op) begin
                diff_cell_val <= user_data;
            end
            // Seeds are the LFSR value seen during the NEW cycle
            if (r_state == c_S_NEW) begin
                rand_setup <= r_lfsr[11:8];
                rand_A     <= r_lfsr[7:4];
                rand_B     <= r_lfsr[3:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sudoku_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sudoku_ctrl
//  Purpose  : Self-checking bench for sudoku_ctrl with a behavioural model of
//             the game sequence and the seed LFSR.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sudoku_ctrl;

    localparam int          FC   = 2;
    localparam logic [11:0] SEED = 12'hACE;

    logic       clka = 1'b0;
    logic       restart;
    logic       btn_new_game;
    logic       btn_enter;
    logic [1:0] user_data;
    logic       solved;
    logic       new_game, set_board_flag, set_diff_flag, row_flag, col_flag;
    logic       val_flag, check_flag, game_won;
    logic [1:0] diff_cell_val;
    logic [3:0] rand_setup, rand_A, rand_B;

    int errors = 0;
    int checks = 0;

    logic [11:0] m_lfsr;
    logic [11:0] exp_rand;
    logic [1:0]  exp_dcv;
    logic [7:0]  flags;
    logic [11:0] rands;

    // Expected flag vector per entry kind: diff, row, col, val(+check)
    logic [7:0] kflag [4] = '{8'h20, 8'h10, 8'h08, 8'h06};

    assign flags = {new_game, set_board_flag, set_diff_flag, row_flag,
                    col_flag, val_flag, check_flag, game_won};
    assign rands = {rand_setup, rand_A, rand_B};

    sudoku_ctrl #(.FLAG_CYCLES(FC), .LFSR_SEED(SEED)) dut (
        .clka           (clka),
        .restart        (restart),
        .btn_new_game   (btn_new_game),
        .btn_enter      (btn_enter),
        .user_data      (user_data),
        .solved         (solved),
        .new_game       (new_game),
        .set_board_flag (set_board_flag),
        .set_diff_flag  (set_diff_flag),
        .row_flag       (row_flag),
        .col_flag       (col_flag),
        .val_flag       (val_flag),
        .check_flag     (check_flag),
        .diff_cell_val  (diff_cell_val),
        .rand_setup     (rand_setup),
        .rand_A         (rand_A),
        .rand_B         (rand_B),
        .game_won       (game_won)
    );

    always #5 clka = ~clka;

    // Reference LFSR: polynomial x^12+x^6+x^4+x+1 as a feedback mask
    always @(posedge clka or posedge restart) begin
        if (restart) m_lfsr <= SEED;
        else         m_lfsr <= {m_lfsr[10:0], ^(m_lfsr & 12'h829)};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Apply inputs for one cycle starting at a falling edge; returns at the next one
    task automatic drive(input logic ent, input logic ng, input logic [1:0] ud, input logic sv);
        btn_enter    = ent;
        btn_new_game = ng;
        user_data    = ud;
        solved       = sv;
        @(negedge clka);
        btn_enter    = 1'b0;
        btn_new_game = 1'b0;
    endtask

    task automatic test_reset();
        restart = 1'b1;
        repeat (2) @(negedge clka);
        restart = 1'b0;
        exp_dcv = 2'b00;
        checks++;
        if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 8'h00); end
        checks++;
        if (diff_cell_val !== 2'b00) begin errors++; $display("FAIL reset_dcv: got %0d want 0", diff_cell_val); end
        checks++;
        if (rands !== 12'h000) begin errors++; $display("FAIL reset_rand: got %h want 000", rands); end
        // Idle ignores enter and switch activity
        repeat ($urandom_range(3, 6)) begin
            drive(1'($urandom), 1'b0, 2'($urandom), 1'($urandom));
            checks++;
            if (flags !== 8'h00 || diff_cell_val !== 2'b00) begin
                errors++; $display("FAIL idle_quiet: flags %b dcv %0d want 0/0", flags, diff_cell_val);
            end
        end
    endtask

    // Press new game (optionally together with enter) and follow it through BOARD
    task automatic start_game(input logic with_enter);
        drive(with_enter, 1'b1, 2'($urandom), 1'b0);
        checks++;
        if (flags !== 8'h80) begin errors++; $display("FAIL new_pulse: got %b want %b", flags, 8'h80); end
        exp_rand = m_lfsr;
        for (int i = 0; i < FC; i++) begin
            drive(1'($urandom), 1'b0, 2'($urandom), 1'($urandom));
            checks++;
            if (flags !== 8'h40) begin errors++; $display("FAIL board_flag[%0d]: got %b want %b", i, flags, 8'h40); end
            checks++;
            if (rands !== exp_rand) begin errors++; $display("FAIL seed_latch: got %h want %h", rands, exp_rand); end
        end
        drive(1'b0, 1'b0, 2'($urandom), 1'b0);
        checks++;
        if (flags !== 8'h00 || diff_cell_val !== exp_dcv) begin
            errors++; $display("FAIL diff_wait: flags %b dcv %0d want 0/%0d", flags, diff_cell_val, exp_dcv);
        end
    endtask

    // Enter one operand from a wait state and check the resulting flag window
    task automatic enter_cell(input int kind, input logic [1:0] val, input logic solved_v);
        repeat ($urandom_range(0, 2)) begin
            drive(1'b0, 1'b0, 2'($urandom), 1'b0);
            checks++;
            if (flags !== 8'h00 || diff_cell_val !== exp_dcv) begin
                errors++; $display("FAIL wait_quiet: flags %b dcv %0d want 0/%0d", flags, diff_cell_val, exp_dcv);
            end
        end
        drive(1'b1, 1'b0, val, 1'b0);
        exp_dcv = val;
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (flags !== kflag[kind] || diff_cell_val !== exp_dcv) begin
                errors++;
                $display("FAIL flag_k%0d[%0d]: flags %b dcv %0d want %b/%0d",
                         kind, i, flags, diff_cell_val, kflag[kind], exp_dcv);
            end
            drive(1'($urandom), 1'b0, 2'($urandom), 1'($urandom));
        end
        if (kind == 3) begin
            checks++;
            if (flags !== 8'h02 || diff_cell_val !== exp_dcv) begin
                errors++; $display("FAIL check_tail: flags %b dcv %0d want %b/%0d", flags, diff_cell_val, 8'h02, exp_dcv);
            end
            drive(1'b0, 1'b0, 2'($urandom), solved_v);
            checks++;
            if (flags !== (solved_v ? 8'h01 : 8'h00)) begin
                errors++; $display("FAIL check_result: got %b want %b", flags, solved_v ? 8'h01 : 8'h00);
            end
        end else begin
            checks++;
            if (flags !== 8'h00) begin errors++; $display("FAIL after_k%0d: got %b want 0", kind, flags); end
        end
        checks++;
        if (rands !== exp_rand) begin errors++; $display("FAIL seed_hold: got %h want %h", rands, exp_rand); end
    endtask

    task automatic test_full_entry();
        start_game(1'b0);
        enter_cell(0, 2'b01, 1'b0);
        enter_cell(1, 2'b10, 1'b0);
        enter_cell(2, 2'b11, 1'b0);
        enter_cell(3, 2'b01, 1'b0);
        repeat (2) begin
            enter_cell(1, 2'($urandom), 1'b0);
            enter_cell(2, 2'($urandom), 1'b0);
            enter_cell(3, 2'($urandom), 1'b0);
        end
    endtask

    task automatic test_solved();
        enter_cell(1, 2'($urandom), 1'b0);
        enter_cell(2, 2'($urandom), 1'b0);
        enter_cell(3, 2'($urandom), 1'b1);
        repeat (3) begin
            drive(1'b1, 1'b0, 2'($urandom), 1'($urandom));
            checks++;
            if (flags !== 8'h01 || diff_cell_val !== exp_dcv) begin
                errors++; $display("FAIL won_hold: flags %b dcv %0d want %b/%0d", flags, diff_cell_val, 8'h01, exp_dcv);
            end
        end
    endtask

    // Starts from WON: new game restarts, then is aborted mid row flag
    task automatic test_back_to_back_abort();
        logic [1:0] v;
        start_game(1'b0);
        enter_cell(0, 2'($urandom), 1'b0);
        v = 2'($urandom);
        drive(1'b1, 1'b0, v, 1'b0);
        exp_dcv = v;
        checks++;
        if (flags !== 8'h10) begin errors++; $display("FAIL abort_pre_row: got %b want %b", flags, 8'h10); end
        start_game(1'b1);
        enter_cell(0, 2'($urandom), 1'b0);
    endtask

    task automatic test_async_reset();
        logic [1:0] v;
        enter_cell(1, 2'($urandom), 1'b0);
        enter_cell(2, 2'($urandom), 1'b0);
        v = 2'($urandom);
        drive(1'b1, 1'b0, v, 1'b0);
        exp_dcv = v;
        checks++;
        if (flags !== 8'h06) begin errors++; $display("FAIL pre_reset_val: got %b want %b", flags, 8'h06); end
        #2 restart = 1'b1;
        #1;
        checks++;
        if (flags !== 8'h00) begin errors++; $display("FAIL async_flags: got %b want 0", flags); end
        checks++;
        if (diff_cell_val !== 2'b00 || rands !== 12'h000) begin
            errors++; $display("FAIL async_regs: dcv %0d rand %h want 0/000", diff_cell_val, rands);
        end
        exp_dcv = 2'b00;
        @(negedge clka);
        @(negedge clka);
        restart = 1'b0;
        repeat (3) begin
            drive(1'b1, 1'b0, 2'($urandom), 1'b0);
            checks++;
            if (flags !== 8'h00 || diff_cell_val !== 2'b00) begin
                errors++; $display("FAIL post_reset_idle: flags %b dcv %0d want 0/0", flags, diff_cell_val);
            end
        end
        start_game(1'b0);
    endtask

    initial begin
        restart      = 1'b1;
        btn_new_game = 1'b0;
        btn_enter    = 1'b0;
        user_data    = 2'b00;
        solved       = 1'b0;
        exp_rand     = 12'h000;
        exp_dcv      = 2'b00;
        @(negedge clka);
        test_reset();
        test_full_entry();
        test_solved();
        test_back_to_back_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
